matrix_code_enc: RTL



---
 rtl/matrix_code_enc.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/matrix_code_enc.sv
// Streaming encoder for the 4x4 byte matrix code: 16 data bytes in, 32-byte codeword out
// (each row followed by three row checks, then four column parities), with optional fault injection.
module matrix_code_enc #(
   parameter int W              = 8,
   parameter int INJ_EN_DEFAULT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         dout_chk,
   output logic         dout_last,
   input  logic         inj_arm,
   input  logic [3:0]   inj_pos,
   input  logic [W-1:0] inj_mask,
   output logic         busy
);

   typedef enum logic [1:0] {DATA, ROWCHK, COLPAR} state_t;

   state_t       state;
   logic [1:0]   row;
   logic [1:0]   col;
   logic [1:0]   k;
   logic [1:0]   j;
   logic [W-1:0] r [4];
   logic [W-1:0] c [4];
   logic         inj_flag;

   logic         load_ok;
   logic         din_fire;
   logic         inj_hit;
   logic [W-1:0] inj_xor;
   logic [W-1:0] row_chk;

   assign load_ok   = !dout_valid || dout_ready;
   assign din_ready = (state == DATA) && load_ok;
   assign din_fire  = din_valid && din_ready;
   assign inj_hit   = inj_flag && ({row, col} == inj_pos);
   assign inj_xor   = inj_hit ? inj_mask : '0;

   // Each row check leaves out exactly one of the four data bytes of the row.
   always_comb begin
      row_chk = r[0] ^ r[1] ^ r[2];
      case (k)
         2'd1:    row_chk = r[0] ^ r[1] ^ r[3];
         2'd2:    row_chk = r[0] ^ r[2] ^ r[3];
         default: row_chk = r[0] ^ r[1] ^ r[2];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DATA;
         row        <= 2'd0;
         col        <= 2'd0;
         k          <= 2'd0;
         j          <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            r[i] <= '0;
            c[i] <= '0;
         end
         inj_flag   <= (INJ_EN_DEFAULT != 0);
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_chk   <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (dout_valid && dout_ready)
            dout_valid <= 1'b0;

         // A new codeword's first accept can coincide with the previous last byte leaving.
         if (din_fire)
            busy <= 1'b1;
         else if (dout_valid && dout_ready && dout_last)
            busy <= 1'b0;

         if (inj_arm && !busy)
            inj_flag <= 1'b1;

         case (state)
            DATA: begin
               if (din_fire) begin
                  dout       <= din ^ inj_xor;
                  dout_valid <= 1'b1;
                  dout_chk   <= 1'b0;
                  dout_last  <= 1'b0;
                  r[col]     <= din;
                  c[col]     <= c[col] ^ din;
                  if (col == 2'd3) begin
                     state <= ROWCHK;
                     k     <= 2'd0;
                     col   <= 2'd0;
                  end else begin
                     col <= col + 2'd1;
                  end
               end
            end
            ROWCHK: begin
               if (load_ok) begin
                  dout       <= row_chk;
                  dout_valid <= 1'b1;
                  dout_chk   <= 1'b1;
                  dout_last  <= 1'b0;
                  if (k == 2'd2) begin
                     row <= row + 2'd1;
                     if (row == 2'd3) begin
                        state <= COLPAR;
                        j     <= 2'd0;
                     end else begin
                        state <= DATA;
                        col   <= 2'd0;
                     end
                  end else begin
                     k <= k + 2'd1;
                  end
               end
            end
            COLPAR: begin
               if (load_ok) begin
                  dout       <= c[j];
                  dout_valid <= 1'b1;
                  dout_chk   <= 1'b1;
                  dout_last  <= (j == 2'd3);
                  if (j == 2'd3) begin
                     for (int i = 0; i < 4; i++)
                        c[i] <= '0;
                     row      <= 2'd0;
                     col      <= 2'd0;
                     inj_flag <= 1'b0;
                     state    <= DATA;
                  end else begin
                     j <= j + 2'd1;
                  end
               end
            end
            default: state <= DATA;
         endcase
      end
   end

endmodule
